// File: rtl/trng_controller_pkg.sv
// Shared types, default parameters and helpers for the TRNG sequencer.
package trng_controller_pkg;

  // Default build parameters
  localparam int unsigned DEF_WORD_WIDTH    = 32;
  localparam int unsigned DEF_WARMUP_CYCLES = 1024;
  localparam int unsigned DEF_SAMPLE_DIV    = 16;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  // Health-test (repetition count) defaults
  localparam int unsigned DEF_REP_LIMIT     = 32;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  // Bits needed to hold any value in 0..max_val (never less than one)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trng_bit_sync.sv
// Multi-flop synchroniser bringing the free-running RO sample bit into iClk.
module trng_bit_sync
  import trng_controller_pkg::*;
#(
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iAsyncBit,
  output logic oSyncBit
);

  // Chain must stay intact so each stage gets a full cycle to resolve
  (* dont_touch = "true" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw bit in at the bottom of the chain
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], iAsyncBit};
  end

  // Synchroniser flops
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign oSyncBit = sync_q[STAGES-1];

endmodule

// File: rtl/trng_controller.sv
// Ring-oscillator TRNG sequencer: warm-up, decimating sampler, repetition-count
// health test and valid/ready word hand-off.
module trng_controller
  import trng_controller_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int unsigned SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int unsigned REP_LIMIT     = DEF_REP_LIMIT,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iStart,
  input  logic                  iStop,
  output logic                  oEntropyEn,
  output logic                  oRoEn,
  input  logic                  iRandomBit,
  output logic [WORD_WIDTH-1:0] oData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oBusy,
  output logic                  oHealthFail
);

  localparam int unsigned WARM_W = cnt_width(WARMUP_CYCLES - 1);
  localparam int unsigned DIV_W  = cnt_width(SAMPLE_DIV - 1);
  localparam int unsigned BIT_W  = cnt_width(WORD_WIDTH - 1);
  localparam int unsigned REP_W  = cnt_width(REP_LIMIT);

  state_e                state_q, state_d;
  logic [WARM_W-1:0]     warm_cnt_q, warm_cnt_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
  logic                  last_bit_q, last_bit_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ro_en_q, ro_en_d;
  logic                  busy_q, busy_d;
  logic                  fail_q, fail_d;

  logic                  sync_bit;
  logic                  warm_done;
  logic                  sample_tick;
  logic                  word_done;
  logic                  health_trip;
  logic                  handshake;
  logic [WORD_WIDTH-1:0] shift_in;
  logic [REP_W-1:0]      rep_next;

  // Raw RO bit into the iClk domain
  trng_bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_bit_sync (
    .iClk      (iClk),
    .iRst      (iRst),
    .iAsyncBit (iRandomBit),
    .oSyncBit  (sync_bit)
  );

  // Decode counter terminal values and handshake
  always_comb begin
    warm_done   = (warm_cnt_q == WARM_W'(WARMUP_CYCLES - 1));
    sample_tick = (state_q == ST_COLLECT) && (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
    word_done   = sample_tick && (bit_cnt_q == BIT_W'(WORD_WIDTH - 1));
    health_trip = (rep_cnt_q == REP_W'(REP_LIMIT));
    handshake   = valid_q && iReady;
    shift_in    = {shift_q[WORD_WIDTH-2:0], sync_bit};
  end

  // Run-length of identical samples, saturating at the failure threshold
  always_comb begin
    rep_next = REP_W'(1);
    if ((rep_cnt_q != '0) && (sync_bit == last_bit_q)) begin
      if (health_trip) begin
        rep_next = rep_cnt_q;
      end else begin
        rep_next = rep_cnt_q + REP_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a tripped health test outranks a stop request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iStart && !iStop) begin
          state_d = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (health_trip) begin
          state_d = ST_FAIL;
        end else if (iStop) begin
          state_d = ST_IDLE;
        end else if (warm_done) begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (health_trip) begin
          state_d = ST_FAIL;
        end else if (iStop) begin
          state_d = ST_IDLE;
        end else if (word_done) begin
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (health_trip) begin
          state_d = ST_FAIL;
        end else if (iStop) begin
          state_d = ST_IDLE;
        end else if (handshake) begin
          state_d = ST_COLLECT;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    warm_cnt_d = warm_cnt_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rep_cnt_d  = rep_cnt_q;
    last_bit_d = last_bit_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ro_en_d    = ro_en_q;
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_FAIL);
    fail_d     = fail_q || (state_d == ST_FAIL);

    unique case (state_q)
      ST_IDLE: begin
        if (state_d == ST_WARMUP) begin
          warm_cnt_d = '0;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
          rep_cnt_d  = '0;
          last_bit_d = 1'b0;
          ro_en_d    = 1'b1;
        end
      end
      ST_WARMUP: begin
        warm_cnt_d = warm_done ? '0 : warm_cnt_q + WARM_W'(1);
      end
      ST_COLLECT: begin
        div_cnt_d = sample_tick ? '0 : div_cnt_q + DIV_W'(1);
        if (sample_tick) begin
          shift_d    = shift_in;
          rep_cnt_d  = rep_next;
          last_bit_d = sync_bit;
          bit_cnt_d  = word_done ? '0 : bit_cnt_q + BIT_W'(1);
          if (word_done) begin
            data_d  = shift_in;
            valid_d = 1'b1;
          end
        end
      end
      ST_OUTPUT: begin
        if (handshake) begin
          valid_d   = 1'b0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      default: begin
      end
    endcase

    // Abort or failure: power down the ROs and drop any partial word
    if ((state_d == ST_IDLE) || (state_d == ST_FAIL)) begin
      ro_en_d   = 1'b0;
      valid_d   = 1'b0;
      bit_cnt_d = '0;
      div_cnt_d = '0;
      shift_d   = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      warm_cnt_q <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rep_cnt_q  <= '0;
      last_bit_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ro_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rep_cnt_q  <= rep_cnt_d;
      last_bit_q <= last_bit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ro_en_q    <= ro_en_d;
      busy_q     <= busy_d;
      fail_q     <= fail_d;
    end
  end

  assign oEntropyEn  = ro_en_q;
  assign oRoEn       = ro_en_q;
  assign oData       = data_q;
  assign oValid      = valid_q;
  assign oBusy       = busy_q;
  assign oHealthFail = fail_q;

endmodule

// File: tb/tb_trng_controller.sv
// Directed bench for trng_controller with small parameters.
module tb_trng_controller;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic       iStart = 1'b0;
  logic       iStop = 1'b0;
  logic       iRandomBit = 1'b0;
  logic       iReady = 1'b0;
  logic       oEntropyEn;
  logic       oRoEn;
  logic [7:0] oData;
  logic       oValid;
  logic       oBusy;
  logic       oHealthFail;

  int total = 0;
  int bad   = 0;

  always #5 iClk = ~iClk;

  trng_controller #(
    .WORD_WIDTH    (8),
    .WARMUP_CYCLES (4),
    .SAMPLE_DIV    (2),
    .REP_LIMIT     (6),
    .SYNC_STAGES   (2)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iStart      (iStart),
    .iStop       (iStop),
    .oEntropyEn  (oEntropyEn),
    .oRoEn       (oRoEn),
    .iRandomBit  (iRandomBit),
    .oData       (oData),
    .oValid      (oValid),
    .iReady      (iReady),
    .oBusy       (oBusy),
    .oHealthFail (oHealthFail)
  );

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the edge that enters COLLECT, with pat[7] already on
  // iRandomBit. Bit k must be on the pin one cycle before it is captured by
  // the first sync flop, two edges ahead of its sample edge.
  task automatic feed(input logic [7:0] pat, input int n, input logic nxt);
    tick();
    for (int k = 1; k < n; k++) begin
      iRandomBit = pat[7-k];
      tick();
      tick();
    end
    tick();
    iRandomBit = nxt;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 iRst = 1'b1;
    tick();
    tick();
    chk("rst_roen",  32'(oRoEn), 32'd0);
    chk("rst_enten", 32'(oEntropyEn), 32'd0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_busy",  32'(oBusy), 32'd0);
    chk("rst_fail",  32'(oHealthFail), 32'd0);
    chk("rst_data",  32'(oData), 32'd0);
    iRst = 1'b0;
    tick();

    // Start and stop together in IDLE: stay idle
    iStart = 1'b1;
    iStop  = 1'b1;
    tick();
    iStart = 1'b0;
    iStop  = 1'b0;
    chk("startstop_busy", 32'(oBusy), 32'd0);
    chk("startstop_roen", 32'(oRoEn), 32'd0);

    // Start: ROs rise on the capturing edge
    iRandomBit = 1'b1;
    iStart = 1'b1;
    chk("pre_start_roen", 32'(oRoEn), 32'd0);
    tick();
    iStart = 1'b0;
    chk("start_roen",  32'(oRoEn), 32'd1);
    chk("start_enten", 32'(oEntropyEn), 32'd1);
    chk("start_busy",  32'(oBusy), 32'd1);
    chk("start_valid", 32'(oValid), 32'd0);
    tick();
    tick();
    tick();
    chk("warm_busy",  32'(oBusy), 32'd1);
    chk("warm_valid", 32'(oValid), 32'd0);
    tick();

    // Word 1: 1,0,1,1,0,0,1,0 with immediate acceptance
    iReady = 1'b1;
    feed(8'hB2, 8, 1'b0);
    chk("w1_valid", 32'(oValid), 32'd1);
    chk("w1_data",  32'(oData), 32'hB2);
    tick();
    iReady = 1'b0;
    chk("w1_acc_valid", 32'(oValid), 32'd0);
    chk("w1_acc_busy",  32'(oBusy), 32'd1);
    chk("w1_acc_roen",  32'(oRoEn), 32'd1);

    // Word 2: held with iReady low for 10 cycles while the raw bit toggles
    feed(8'h5A, 8, 1'b0);
    chk("w2_valid", 32'(oValid), 32'd1);
    chk("w2_data",  32'(oData), 32'h5A);
    for (int i = 0; i < 10; i++) begin
      iRandomBit = i[0];
      tick();
      chk("w2_hold_valid", 32'(oValid), 32'd1);
      chk("w2_hold_data",  32'(oData), 32'h5A);
    end
    iRandomBit = 1'b1;
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    chk("w2_acc_valid", 32'(oValid), 32'd0);
    chk("w2_acc_busy",  32'(oBusy), 32'd1);

    // Start while busy is ignored; then stop after three samples
    iStart = 1'b1;
    feed(8'hE0, 3, 1'b1);
    iStart = 1'b0;
    chk("busy_start_valid", 32'(oValid), 32'd0);
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
    chk("stop_busy",  32'(oBusy), 32'd0);
    chk("stop_roen",  32'(oRoEn), 32'd0);
    chk("stop_enten", 32'(oEntropyEn), 32'd0);
    chk("stop_valid", 32'(oValid), 32'd0);
    tick();
    chk("idle_valid", 32'(oValid), 32'd0);
    chk("idle_busy",  32'(oBusy), 32'd0);

    // Restart: a fresh full word with nothing left from the aborted one
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("restart_roen", 32'(oRoEn), 32'd1);
    tick();
    tick();
    tick();
    tick();
    iReady = 1'b1;
    feed(8'hC2, 8, 1'b1);
    chk("w3_valid", 32'(oValid), 32'd1);
    chk("w3_data",  32'(oData), 32'hC2);
    tick();
    chk("w3_acc_valid", 32'(oValid), 32'd0);

    // Six identical 1 samples: failure on the edge after the sixth
    for (int i = 0; i < 12; i++) begin
      tick();
    end
    chk("rep6_fail_pending", 32'(oHealthFail), 32'd0);
    chk("rep6_busy",         32'(oBusy), 32'd1);
    tick();
    chk("fail_flag",  32'(oHealthFail), 32'd1);
    chk("fail_roen",  32'(oRoEn), 32'd0);
    chk("fail_enten", 32'(oEntropyEn), 32'd0);
    chk("fail_valid", 32'(oValid), 32'd0);
    chk("fail_busy",  32'(oBusy), 32'd0);

    // FAIL ignores start and stop
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    chk("fail_start_flag", 32'(oHealthFail), 32'd1);
    chk("fail_start_roen", 32'(oRoEn), 32'd0);
    chk("fail_start_busy", 32'(oBusy), 32'd0);
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
    chk("fail_stop_flag", 32'(oHealthFail), 32'd1);

    // Only reset clears the failure
    iReady = 1'b0;
    iRst = 1'b1;
    #1;
    chk("fail_rst_flag", 32'(oHealthFail), 32'd0);
    tick();
    iRst = 1'b0;

    // Reset asserted while a word waits in OUTPUT
    iRandomBit = 1'b1;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    tick();
    tick();
    tick();
    feed(8'h96, 8, 1'b0);
    chk("w4_valid", 32'(oValid), 32'd1);
    chk("w4_data",  32'(oData), 32'h96);
    #2 iRst = 1'b1;
    #1;
    chk("async_rst_data",  32'(oData), 32'd0);
    chk("async_rst_valid", 32'(oValid), 32'd0);
    chk("async_rst_roen",  32'(oRoEn), 32'd0);
    chk("async_rst_enten", 32'(oEntropyEn), 32'd0);
    chk("async_rst_busy",  32'(oBusy), 32'd0);
    tick();
    iRst = 1'b0;
    tick();
    tick();
    tick();
    chk("post_rst_busy",  32'(oBusy), 32'd0);
    chk("post_rst_roen",  32'(oRoEn), 32'd0);
    chk("post_rst_valid", 32'(oValid), 32'd0);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("post_rst_start_roen", 32'(oRoEn), 32'd1);
    chk("post_rst_start_busy", 32'(oBusy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
